// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 widths, fault decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads, so a store with funct3[2] set is illegal.
  function automatic logic is_fault(input logic write, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic f;
    case (funct3)
      F3_B, F3_BU: f = 1'b0;
      F3_H, F3_HU: f = addr_lo[0];
      F3_W:        f = (addr_lo != 2'b00);
      default:     f = 1'b1;
    endcase
    return f | (write & funct3[2]);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus word-only memory port of the load/store unit.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: extends the addressed byte/halfword of a word for loads
// and splices store data into that lane for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = i_word;
    o_merged    = i_wdata;
    case (i_f3)
      F3_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU: o_load_data = {24'd0, w_byte};
      F3_H:  o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU: o_load_data = {16'd0, w_half};
      default: o_load_data = i_word;
    endcase
    case (i_f3)
      F3_B, F3_BU: begin
        o_merged = i_word;
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      end
      F3_H, F3_HU: begin
        o_merged = i_word;
        o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store front end for a word-only memory with async read.
// One request in flight; sub-word stores run as read-modify-write, faults skip memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  state_t                r_state;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_merge;
  logic                  r_fault;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;
  logic                  w_fault;

  assign w_fault = is_fault(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  lsu_lane_align u_align (
    .i_f3        (r_f3),
    .i_addr_lo   (r_addr[1:0]),
    .i_word      (bus.mem_rd),
    .i_wdata     (r_wdata),
    .o_load_data (w_load),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_merge <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_f3    <= bus.req_funct3;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_fault <= w_fault;
            if (w_fault)                   r_state <= ST_RESP;
            else if (!bus.req_write)       r_state <= ST_LOAD;
            else if (bus.req_funct3 == F3_W) r_state <= ST_STORE;
            else                           r_state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          r_rdata <= w_load;
          r_state <= ST_RESP;
        end
        ST_STORE:  r_state <= ST_RESP;
        ST_RMW_RD: begin
          r_merge <= w_merged;
          r_state <= ST_RMW_WR;
        end
        ST_RMW_WR: r_state <= ST_RESP;
        ST_RESP:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so reset kills mem_we at once.
  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_fault = (r_state == ST_RESP) & r_fault;
  assign bus.rsp_rdata = r_rdata;
  assign bus.mem_we    = (r_state == ST_STORE) || (r_state == ST_RMW_WR);
  assign bus.mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wd    = (r_state == ST_RMW_WR) ? r_merge : r_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner cases,
// and random traffic against a word-array reference model.
module tb_load_store_unit;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory seen by the DUT.
  logic [31:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;

  logic [31:0] ref_mem [0:63];

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_nwe;
  } vec_t;

  vec_t vecs [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RISC-V byte/half/word semantics over a plain word array.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [7:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic fault, output int lat);
    int          lo  = addr % 4;
    int          idx = addr / 4;
    int          sz  = f3 % 4;
    bit          uns = f3[2];
    logic [31:0] word = ref_mem[idx];
    logic [31:0] sh   = word >> (8 * lo);
    logic [31:0] mask;
    rdata = 32'd0;
    fault = (sz == 3) || (f3 == 3'd6) || (wr && uns) ||
            (sz == 1 && (addr % 2) != 0) || (sz == 2 && lo != 0);
    if (fault) lat = 1;
    else if (!wr) begin
      lat = 2;
      if (sz == 0) begin
        rdata = sh & 32'hFF;
        if (!uns && rdata >= 128) rdata = rdata - 256;
      end else if (sz == 1) begin
        rdata = sh & 32'hFFFF;
        if (!uns && rdata >= 32768) rdata = rdata - 65536;
      end else rdata = word;
    end else if (sz == 2) begin
      lat = 2;
      ref_mem[idx] = wdata;
    end else begin
      lat  = 3;
      mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * lo);
      ref_mem[idx] = (word & ~mask) | ((wdata << (8 * lo)) & mask);
    end
  endtask

  // Issue one request and follow it to rsp_valid, counting edges and write cycles.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [7:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic fault, output int lat, output int nwe,
                        output logic [31:0] we_addr);
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = {24'd0, addr};
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat     = 1;
    nwe     = 0;
    we_addr = 32'd0;
    while (!bus.rsp_valid && lat < 8) begin
      if (bus.mem_we) begin
        nwe++;
        we_addr = bus.mem_addr;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    fault = bus.rsp_fault;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, mrd, wa;
    logic        flt, mflt;
    int          lat, mlat, nwe, seen;
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd;

    vecs[0]  = '{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[1]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 3'b010, 8'h10, 32'h11223344, 32'h0,        1'b0, 2, 1};
    vecs[3]  = '{1'b1, 3'b000, 8'h11, 32'hFFFFFF80, 32'h0,        1'b0, 3, 1};
    vecs[4]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h11228044, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 3'b000, 8'h11, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 3'b100, 8'h11, 32'h0,        32'h00000080, 1'b0, 2, 0};
    vecs[7]  = '{1'b1, 3'b001, 8'h12, 32'h1234BEEF, 32'h0,        1'b0, 3, 1};
    vecs[8]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hBEEF8044, 1'b0, 2, 0};
    vecs[9]  = '{1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0};
    vecs[10] = '{1'b0, 3'b101, 8'h12, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 3'b010, 8'h13, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[12] = '{1'b1, 3'b001, 8'h11, 32'hAAAA5555, 32'h0,        1'b1, 1, 0};
    vecs[13] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[14] = '{1'b1, 3'b100, 8'h10, 32'h000000AA, 32'h0,        1'b1, 1, 0};
    vecs[15] = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hBEEF8044, 1'b0, 2, 0};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    reset = 1'b1;
    #1;
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset mem_we",    {31'd0, bus.mem_we}, 32'd0);
    check("reset mem_addr",  bus.mem_addr, 32'd0);
    check("reset mem_wd",    bus.mem_wd, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Fill every word so memory and model start identical.
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      model(1'b1, 3'b010, 8'(i * 4), wd, mrd, mflt, mlat);
      do_req(1'b1, 3'b010, 8'(i * 4), wd, rd, flt, lat, nwe, wa);
    end

    for (int i = 0; i < 16; i++) begin
      model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mflt, mlat);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat, nwe, wa);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d fault", i), {31'd0, flt}, {31'd0, vecs[i].exp_fault});
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d we_cycles", i), nwe, vecs[i].exp_nwe);
      if (vecs[i].exp_nwe == 1)
        check($sformatf("vec%0d we_addr", i), wa, {24'd0, vecs[i].addr & 8'hFC});
    end

    // Loaded data persists in IDLE, then a mid-cycle reset clears it immediately.
    do_req(1'b0, 3'b010, 8'h10, 32'h0, rd, flt, lat, nwe, wa);
    @(posedge clk);
    #1;
    check("rdata held in idle", bus.rsp_rdata, 32'hBEEF8044);
    #2 reset = 1'b1;
    #1;
    check("midreset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midreset mem_we",    {31'd0, bus.mem_we}, 32'd0);
    check("midreset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("midreset rsp_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset landing inside RMW_WR must abort the write and the response.
    model(1'b1, 3'b010, 8'h10, 32'h11223344, mrd, mflt, mlat);
    do_req(1'b1, 3'b010, 8'h10, 32'h11223344, rd, flt, lat, nwe, wa);
    @(negedge clk);
    if (!bus.req_ready) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h80;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rmw_rd mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    #1;
    check("rmw_wr mem_we", {31'd0, bus.mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rmw reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    check("rmw reset no rsp", seen, 0);
    check("rmw reset word", mem[4], 32'h11223344);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 8'($urandom_range(0, 255));
      wd   = $urandom;
      model(wr, f3, addr, wd, mrd, mflt, mlat);
      do_req(wr, f3, addr, wd, rd, flt, lat, nwe, wa);
      check($sformatf("rand%0d rdata", i), rd, mrd);
      check($sformatf("rand%0d fault", i), {31'd0, flt}, {31'd0, mflt});
      check($sformatf("rand%0d latency", i), lat, mlat);
    end

    for (int i = 0; i < 64; i++)
      check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
